quad_encoder_gen: RTL

- Quadrature encoder emulator. It is the transmitting end of the rotary-encoder interface that the RGB mixer's encoder inputs decode.
- Accepts signed step commands over a valid/ready handshake and emits A/B quadrature waveforms with a programmable edge spacing.
- Used as an on-chip stimulus source and self-test driver for the encoder/PWM mixer path. It also tracks the emitted position.

---
 rtl/quad_encoder_gen_if.sv | 29 ++
 rtl/quad_encoder_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/quad_encoder_gen_if.sv
// quad_encoder_gen_if
//   Command channel of the quadrature encoder emulator.
//   Signals:
//     cmd_valid  - sender has a command on cmd_steps/cmd_period
//     cmd_ready  - emulator can accept a command this cycle
//     cmd_steps  - signed edge count (two's complement), sign = direction
//     cmd_period - clk cycles between successive edges (0 treated as 1)
//     abort      - synchronous cancel of the running command
//   Modports: master = command sender, slave = encoder emulator.
interface quad_encoder_gen_if #(
  parameter int STEP_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [STEP_WIDTH-1:0] cmd_steps;
  logic [DIV_WIDTH-1:0]  cmd_period;
  logic                  abort;

  modport master (
    output cmd_valid, cmd_steps, cmd_period, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_period, abort,
    output cmd_ready
  );
endinterface

// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen
//   Quadrature encoder emulator: turns signed step commands into A/B
//   quadrature edges spaced cmd_period clocks apart and tracks the
//   signed position of the emitted edges.
//   Ports:
//     clk      - system clock
//     rst_n    - asynchronous active-low reset
//     cmd_if   - command channel (valid/ready, steps, period, abort)
//     enc_a    - quadrature channel A (registered)
//     enc_b    - quadrature channel B (registered)
//     busy     - command in progress
//     done     - one-cycle pulse on command completion
//     position - signed count of emitted edges, wraps
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | waiting for a command; cmd_ready high unless abort
//   ST_RUN  | timer counting down, one edge per terminal count
module quad_encoder_gen #(
  parameter int STEP_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int POS_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  quad_encoder_gen_if.slave           cmd_if,
  output logic                        enc_a,
  output logic                        enc_b,
  output logic                        busy,
  output logic                        done,
  output logic signed [POS_WIDTH-1:0] position
);

  typedef enum logic [0:0] {ST_IDLE, ST_RUN} state_t;

  localparam logic [STEP_WIDTH-1:0]       STEP_ONE = STEP_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0]        DIV_ONE  = DIV_WIDTH'(1);
  localparam logic signed [POS_WIDTH-1:0] POS_ONE  = POS_WIDTH'(1);

  state_t                        r_state,     w_state_nxt;
  logic [DIV_WIDTH-1:0]          r_timer,     w_timer_nxt;
  logic [DIV_WIDTH-1:0]          r_period,    w_period_nxt;
  logic [STEP_WIDTH-1:0]         r_remaining, w_remaining_nxt;
  logic                          r_dir,       w_dir_nxt;
  logic [1:0]                    r_enc,       w_enc_nxt;
  logic signed [POS_WIDTH-1:0]   r_position,  w_position_nxt;
  logic                          r_busy,      w_busy_nxt;
  logic                          r_done,      w_done_nxt;

  logic                  w_cmd_ready;
  logic                  w_accept;
  logic [STEP_WIDTH-1:0] w_steps_raw;
  logic [STEP_WIDTH-1:0] w_steps_mag;
  logic [DIV_WIDTH-1:0]  w_eff_period;
  logic [1:0]            w_phase_step;

  // rst_n gates ready so nothing upstream sees a ready while held in reset
  assign w_cmd_ready      = (r_state == ST_IDLE) & ~cmd_if.abort & rst_n;
  assign cmd_if.cmd_ready = w_cmd_ready;
  assign w_accept         = cmd_if.cmd_valid & w_cmd_ready;

  // Two's-complement negate in STEP_WIDTH bits; the most-negative value
  // maps onto its own unsigned magnitude 2^(STEP_WIDTH-1).
  assign w_steps_raw  = cmd_if.cmd_steps;
  assign w_steps_mag  = w_steps_raw[STEP_WIDTH-1] ? (~w_steps_raw + STEP_ONE) : w_steps_raw;
  assign w_eff_period = (cmd_if.cmd_period == '0) ? DIV_ONE : cmd_if.cmd_period;

  // Gray step on {A,B}: forward 00->10->11->01, reverse the opposite way.
  assign w_phase_step = r_dir ? {r_enc[0], ~r_enc[1]} : {~r_enc[0], r_enc[1]};

  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_period_nxt    = r_period;
    w_remaining_nxt = r_remaining;
    w_dir_nxt       = r_dir;
    w_enc_nxt       = r_enc;
    w_position_nxt  = r_position;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_dir_nxt       = w_steps_raw[STEP_WIDTH-1];
          w_period_nxt    = w_eff_period;
          // Load P-1 so the first edge lands exactly P clocks after accept.
          w_timer_nxt     = w_eff_period - DIV_ONE;
          w_remaining_nxt = w_steps_mag;
          if (w_steps_mag == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
            w_busy_nxt  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (cmd_if.abort) begin
          w_state_nxt     = ST_IDLE;
          w_busy_nxt      = 1'b0;
          w_timer_nxt     = '0;
          w_remaining_nxt = '0;
        end else if (r_timer == '0) begin
          w_enc_nxt       = w_phase_step;
          w_position_nxt  = r_dir ? (r_position - POS_ONE) : (r_position + POS_ONE);
          w_remaining_nxt = r_remaining - STEP_ONE;
          w_timer_nxt     = r_period - DIV_ONE;
          if (r_remaining == STEP_ONE) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_timer_nxt = '0;
          end
        end else begin
          w_timer_nxt = r_timer - DIV_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_period    <= '0;
      r_remaining <= '0;
      r_dir       <= 1'b0;
      r_enc       <= 2'b00;
      r_position  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_period    <= w_period_nxt;
      r_remaining <= w_remaining_nxt;
      r_dir       <= w_dir_nxt;
      r_enc       <= w_enc_nxt;
      r_position  <= w_position_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign enc_a    = r_enc[1];
  assign enc_b    = r_enc[0];
  assign busy     = r_busy;
  assign done     = r_done;
  assign position = r_position;

endmodule
